// File: rtl/uart_rx_frame_ctrl_if.sv
// Bundle between the serial pin side and the UART RX frame sequencer.
// master: the sequencer (consumes rx, produces frames); slave: pin driver / frame consumer.
interface uart_rx_frame_ctrl_if;
    logic        rx;
    logic [10:0] buffer;
    logic        frame_valid;
    logic        parity_err;
    logic        frame_err;
    logic        busy;

    modport master (
        input  rx,
        output buffer,
        output frame_valid,
        output parity_err,
        output frame_err,
        output busy
    );

    modport slave (
        output rx,
        input  buffer,
        input  frame_valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame sequencer: synchronizes rx, times bit samples, assembles 11-bit frames.
// Optional macro RX_MAJORITY_EN: 2-of-3 majority vote around each sample point.
module uart_rx_frame_ctrl #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    uart_rx_frame_ctrl_if.master bus
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BRK
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             rx_meta;
    logic             rx_s;
    logic             rx_prev;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_idx;
    logic [9:0]       sh;
    logic [10:0]      buffer_q;
    logic             fv_q;
    logic             pe_q;
    logic             fe_q;
    logic             bit_val;
    logic             tick;
    logic             sh_clr;
    logic             sh_shift;
    logic             load_frame;

`ifdef RX_MAJORITY_EN
    localparam int MAJ_DLY = 1;
    logic rx_prev2;

    // The vote window is point-1/point/point+1, so the decision lands one cycle after the point.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_prev2 <= 1'b1;
        end else begin
            rx_prev2 <= rx_prev;
        end
    end

    assign bit_val = (rx_prev2 & rx_prev) | (rx_prev2 & rx_s) | (rx_prev & rx_s);
`else
    localparam int MAJ_DLY = 0;
    assign bit_val = rx_s;
`endif

    localparam logic [CNT_W-1:0] FIRST_TGT = CNT_W'(CLKS_PER_BIT / 2 - 1 + MAJ_DLY);
    localparam logic [CNT_W-1:0] BIT_TGT   = CNT_W'(CLKS_PER_BIT - 1);

    assign tick = (state == START) ? (cnt == FIRST_TGT) : (cnt == BIT_TGT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        sh_clr     = 1'b0;
        sh_shift   = 1'b0;
        load_frame = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s && rx_prev) begin
                    state_nxt = START;
                end
            end
            START: begin
                if (tick) begin
                    if (bit_val) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = DATA;
                        sh_clr    = 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    sh_shift = 1'b1;
                    if (bit_idx == 4'd8) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    load_frame = 1'b1;
                    state_nxt  = bit_val ? IDLE : BRK;
                end
            end
            BRK: begin
                if (rx_s) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Cleared start bit sits in sh[0]; nine shifts move it to sh[9] with data and parity below.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_prev  <= 1'b1;
            cnt      <= '0;
            bit_idx  <= '0;
            sh       <= '0;
            buffer_q <= '0;
            fv_q     <= 1'b0;
            pe_q     <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;

            if (state == IDLE || state == BRK || tick) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (sh_clr) begin
                sh      <= '0;
                bit_idx <= '0;
            end else if (sh_shift) begin
                sh      <= {sh[8:0], bit_val};
                bit_idx <= bit_idx + 4'd1;
            end

            fv_q <= load_frame;
            if (load_frame) begin
                buffer_q <= {sh, bit_val};
                pe_q     <= (^sh[8:1]) != sh[0];
                fe_q     <= ~bit_val;
            end
        end
    end

    assign bus.buffer      = buffer_q;
    assign bus.frame_valid = fv_q;
    assign bus.parity_err  = pe_q;
    assign bus.frame_err   = fe_q;
    assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Self-checking bench for uart_rx_frame_ctrl: directed cases plus random frames vs. a serial-order model.
// Majority-vote glitch cases run only when RX_MAJORITY_EN is defined.
module tb_uart_rx_frame_ctrl;

    localparam int CPB = 16;
`ifdef RX_MAJORITY_EN
    localparam int MAJ = 1;
`else
    localparam int MAJ = 0;
`endif
    // Edge-to-valid: 10 full bits + half bit to the stop point, 2 sync stages, 1 output register.
    localparam int EXP_LAT = 10 * CPB + CPB / 2 + 3 + MAJ;

    typedef struct {
        logic [10:0] bfr;
        logic        pe;
        logic        fe;
        int          lat;
    } obs_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    int   fv_total = 0;
    int   exp_total = 0;
    logic fv_prev = 1'b0;
    obs_t obs_q[$];

    uart_rx_frame_ctrl_if bus();

    uart_rx_frame_ctrl #(
        .CLKS_PER_BIT(CPB),
        .CNT_W       (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Captures every completed frame and the cycles elapsed since the driven start edge.
    always @(negedge clk) begin
        if (bus.frame_valid === 1'b1) begin
            checkOutput("fv_spacing", {31'b0, fv_prev}, 32'd0);
            obs_q.push_back('{bfr: bus.buffer, pe: bus.parity_err, fe: bus.frame_err,
                              lat: cyc - start_cyc});
            fv_total++;
        end
        fv_prev = bus.frame_valid;
    end

    function automatic logic [10:0] model_buffer(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] serial;
        logic [10:0] res;
        serial[0] = 1'b0;
        for (int i = 0; i < 8; i++) serial[1 + i] = d[i];
        serial[9]  = p;
        serial[10] = s;
        for (int i = 0; i < 11; i++) res[10 - i] = serial[i];
        return res;
    endfunction

    // Drives one serial frame, each bit CPB cycles; optional 1-clk inversion at each data sample point.
    task automatic applyStimulus(input logic [7:0] d, input logic p, input logic s, input bit glitch);
        logic [10:0] serial;
        serial[0] = 1'b0;
        for (int i = 0; i < 8; i++) serial[1 + i] = d[i];
        serial[9]  = p;
        serial[10] = s;
        for (int i = 0; i < 11; i++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (i == 0 && c == 0) start_cyc = cyc;
                if (glitch && i >= 1 && i <= 8 && c == CPB / 2) bus.rx = ~serial[i];
                else bus.rx = serial[i];
            end
        end
    endtask

    task automatic idle(input int n);
        bus.rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_frame(input string tag, input logic [7:0] d, input logic p, input logic s);
        int   n = 0;
        obs_t o;
        exp_total++;
        while (obs_q.size() == 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (obs_q.size() == 0) begin
            checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
        end else begin
            o = obs_q.pop_front();
            checkOutput({tag, "_buffer"}, {21'b0, o.bfr}, {21'b0, model_buffer(d, p, s)});
            checkOutput({tag, "_parity_err"}, {31'b0, o.pe}, {31'b0, ((^d) != p)});
            checkOutput({tag, "_frame_err"}, {31'b0, o.fe}, {31'b0, ~s});
            checkOutput({tag, "_latency"}, o.lat, EXP_LAT);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic       p;
        logic       s;
        int         fv_before;

        // Reset state
        rst    = 1'b1;
        bus.rx = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("rst_fv", {31'b0, bus.frame_valid}, 32'd0);
        checkOutput("rst_buffer", {21'b0, bus.buffer}, 32'd0);
        checkOutput("rst_pe", {31'b0, bus.parity_err}, 32'd0);
        checkOutput("rst_fe", {31'b0, bus.frame_err}, 32'd0);
        idle(10);

        // Clean frame and a wrong-parity frame
        applyStimulus(8'hA5, 1'b0, 1'b1, 1'b0);
        wait_frame("a5", 8'hA5, 1'b0, 1'b1);
        idle(5);
        applyStimulus(8'h01, 1'b0, 1'b1, 1'b0);
        wait_frame("par_err", 8'h01, 1'b0, 1'b1);
        idle(5);

        // Short low glitch: START must abort without a frame
        fv_before = fv_total;
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        bus.rx = 1'b1;
        checkOutput("glitch_busy_hi", {31'b0, bus.busy}, 32'd1);
        repeat (20) @(negedge clk);
        checkOutput("glitch_busy_lo", {31'b0, bus.busy}, 32'd0);
        checkOutput("glitch_no_frame", fv_total, fv_before);

        // Stop bit low then line held low: framing error, busy until line returns high
        applyStimulus(8'h5A, 1'b0, 1'b0, 1'b0);
        repeat (100) @(negedge clk);
        checkOutput("brk_busy_hi", {31'b0, bus.busy}, 32'd1);
        wait_frame("brk", 8'h5A, 1'b0, 1'b0);
        idle(6);
        checkOutput("brk_busy_lo", {31'b0, bus.busy}, 32'd0);

        // Reset in the middle of data bit 4, then a complete frame
        fv_before = fv_total;
        @(negedge clk);
        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            bus.rx = i[0];
            repeat (CPB) @(negedge clk);
        end
        repeat (CPB / 2) @(negedge clk);
        rst    = 1'b1;
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(10);
        checkOutput("abort_buffer", {21'b0, bus.buffer}, 32'd0);
        checkOutput("abort_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("abort_no_frame", fv_total, fv_before);
        applyStimulus(8'h3C, 1'b0, 1'b1, 1'b0);
        wait_frame("after_abort", 8'h3C, 1'b0, 1'b1);
        idle(5);

`ifdef RX_MAJORITY_EN
        applyStimulus(8'hF0, 1'b0, 1'b1, 1'b1);
        wait_frame("maj_f0", 8'hF0, 1'b0, 1'b1);
        idle(5);
`endif

        // Random frames: mostly good parity/stop, occasional errors
        for (int k = 0; k < 12; k++) begin
            d = 8'($urandom);
            p = (^d) ^ ($urandom_range(0, 3) == 0);
            s = ($urandom_range(0, 4) != 0);
            applyStimulus(d, p, s, (MAJ == 1) && ($urandom_range(0, 1) == 1));
            wait_frame($sformatf("rand%0d", k), d, p, s);
            idle($urandom_range(3, 20));
        end

        checkOutput("frame_count", fv_total, exp_total);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
